// File: rtl/dshot_output.sv
// dshot_output: serialises one 16-bit DShot frame (MSB first) onto a motor line.
// Bit timings are derived from clockFrequency at elaboration.
// There is no runtime division: the mode selects one of three precomputed timing sets.
// Optional feature macro: DSHOT_OUTPUT_INVERT_EN.
//   When it is defined, the output is active-low and idles high (bidirectional DShot).
module dshot_output #(
  parameter int clockFrequency = 72_000_000,
  parameter int GUARD_BITS     = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_dshot_value,
  input  logic [15:0] i_dshot_mode,
  input  logic        i_write,
  output logic        o_pwm,
  output logic        o_ready
);

  // Cycle counts per speed (S in kbit/s)
  localparam int P150   = clockFrequency / (150 * 1000);
  localparam int P300   = clockFrequency / (300 * 1000);
  localparam int P600   = clockFrequency / (600 * 1000);
  localparam int T0_150 = clockFrequency * 3 / (8 * 150 * 1000);
  localparam int T0_300 = clockFrequency * 3 / (8 * 300 * 1000);
  localparam int T0_600 = clockFrequency * 3 / (8 * 600 * 1000);
  localparam int T1_150 = clockFrequency * 3 / (4 * 150 * 1000);
  localparam int T1_300 = clockFrequency * 3 / (4 * 300 * 1000);
  localparam int T1_600 = clockFrequency * 3 / (4 * 600 * 1000);

  // Longest interval counted is the DSHOT150 guard; never narrower than one period
  localparam int CNT_MAX = (P150 * GUARD_BITS > P150) ? P150 * GUARD_BITS : P150;
  localparam int CNT_W   = $clog2(CNT_MAX);

`ifdef DSHOT_OUTPUT_INVERT_EN
  localparam logic PWM_IDLE = 1'b1;
`else
  localparam logic PWM_IDLE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, HIGH, LOW, GUARD} state_t;
  typedef enum logic [1:0] {SPD_150, SPD_300, SPD_600} spd_t;

  state_t             state_q, state_d;
  spd_t               spd_q, spd_d, spd_in;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        shift_q, shift_d;
  logic [3:0]         bit_q, bit_d;
  logic               pwm_q, pwm_d;

  logic [CNT_W-1:0]   t0h, t1h, per, grd, high_last;

  // Speed decode of the live mode input; unknown values fall back to DSHOT150
  always_comb begin
    spd_in = SPD_150;
    if (i_dshot_mode == 16'd300)      spd_in = SPD_300;
    else if (i_dshot_mode == 16'd600) spd_in = SPD_600;
  end

  // Timing set of the latched speed, so mid-frame mode changes have no effect
  always_comb begin
    t0h = CNT_W'(T0_150);
    t1h = CNT_W'(T1_150);
    per = CNT_W'(P150);
    grd = CNT_W'(P150 * GUARD_BITS);
    case (spd_q)
      SPD_300: begin
        t0h = CNT_W'(T0_300);
        t1h = CNT_W'(T1_300);
        per = CNT_W'(P300);
        grd = CNT_W'(P300 * GUARD_BITS);
      end
      SPD_600: begin
        t0h = CNT_W'(T0_600);
        t1h = CNT_W'(T1_600);
        per = CNT_W'(P600);
        grd = CNT_W'(P600 * GUARD_BITS);
      end
      default: ;
    endcase
    high_last = (shift_q[15] ? t1h : t0h) - CNT_W'(1);
  end

  // Next-state logic.
  // One counter runs across the whole bit: HIGH covers 0..Thigh-1 and LOW runs on to PERIOD-1.
  always_comb begin
    state_d = state_q;
    spd_d   = spd_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: begin
        if (i_write) begin
          shift_d = i_dshot_value;
          spd_d   = spd_in;
          bit_d   = 4'd0;
          cnt_d   = '0;
          state_d = HIGH;
        end
      end
      HIGH: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == high_last) state_d = LOW;
      end
      LOW: begin
        if (cnt_q == per - CNT_W'(1)) begin
          cnt_d = '0;
          if (bit_q == 4'd15) begin
            state_d = GUARD;
          end else begin
            shift_d = {shift_q[14:0], 1'b0};
            bit_d   = bit_q + 4'd1;
            state_d = HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GUARD: begin
        if (cnt_q == grd - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line register follows the state one cycle late.
  // The first rise therefore lands one cycle after the accepting edge.
  always_comb begin
    pwm_d = (state_q == HIGH) ^ PWM_IDLE;
  end

  // State and datapath registers; reset aborts any frame in flight
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      spd_q   <= SPD_150;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      pwm_q   <= PWM_IDLE;
    end else begin
      state_q <= state_d;
      spd_q   <= spd_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      pwm_q   <= pwm_d;
    end
  end

  assign o_pwm   = pwm_q;
  assign o_ready = (state_q == IDLE);

endmodule

// File: tb/tb_dshot_output.sv
// tb_dshot_output: random and directed frames against a pulse-train reference model.
module tb_dshot_output;

  localparam int CLK_F = 72_000_000;
  localparam int GB    = 2;
`ifdef DSHOT_OUTPUT_INVERT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic        clk, rst_n, wr, pwm, rdy;
  logic [15:0] val, mode;

  int n_cmp = 0;
  int n_bad = 0;

  dshot_output #(.clockFrequency(CLK_F), .GUARD_BITS(GB)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_dshot_value(val), .i_dshot_mode(mode),
    .i_write(wr), .o_pwm(pwm), .o_ready(rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: DShot rules stated in time units of the clock
  function automatic int spd_of(input logic [15:0] m);
    if (m == 16'd300) return 300;
    if (m == 16'd600) return 600;
    return 150;
  endfunction

  function automatic int per_of(input int s);
    return CLK_F / (s * 1000);
  endfunction

  function automatic int hi_of(input int s, input logic b);
    return b ? CLK_F * 3 / (4 * s * 1000) : CLK_F * 3 / (8 * s * 1000);
  endfunction

  function automatic logic line();
    return pwm ^ INV;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one frame and checks every pulse: widths, absolute rise times, ready return.
  // When disturb is set, a stray write with a new value and mode is fired mid-frame.
  task automatic run_frame(input logic [15:0] v, input logic [15:0] m, input bit disturb);
    int t, hs, rt, s, p, inj;
    logic prev, cur;
    int rise_t[$];
    int width[$];
    for (int k = 0; k < 10000 && !rdy; k++) step();
    chk("ready_before_write", int'(rdy), 1);
    val  = v;
    mode = m;
    wr   = 1'b1;
    step();
    wr   = 1'b0;
    chk("ready_fall", int'(rdy), 0);
    chk("no_rise_on_accept", int'(line()), 0);
    s    = spd_of(m);
    p    = per_of(s);
    mode = 16'($urandom_range(0, 700));
    inj  = disturb ? $urandom_range(2, 15 * p) : -1;
    t = 0; hs = 0; rt = -1; prev = 1'b0;
    while (t < 9500) begin
      step();
      t++;
      if (wr) wr = 1'b0;
      cur = line();
      if (cur && !prev) begin
        rise_t.push_back(t);
        hs = t;
      end
      if (!cur && prev) width.push_back(t - hs);
      prev = cur;
      if (rdy) begin
        rt = t;
        break;
      end
      if (t == inj) begin
        wr   = 1'b1;
        val  = 16'($urandom);
        mode = (s == 150) ? 16'd600 : 16'd150;
      end
    end
    wr = 1'b0;
    chk($sformatf("pulse_count v=%h m=%0d", v, m), rise_t.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < rise_t.size())
        chk($sformatf("rise_time bit%0d v=%h m=%0d", i, v, m), rise_t[i], 1 + i * p);
      if (i < width.size())
        chk($sformatf("high_width bit%0d v=%h m=%0d", i, v, m), width[i], hi_of(s, v[15 - i]));
    end
    chk($sformatf("ready_return v=%h m=%0d", v, m), rt, 16 * p + GB * p);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; wr = 1'b0; val = 16'h0; mode = 16'd150;
    // Reset held: line idle, ready high
    for (int k = 0; k < 4; k++) begin
      step();
      chk("reset_pwm", int'(line()), 0);
      chk("reset_ready", int'(rdy), 1);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (line() || !rdy) seen++;
    end
    chk("idle_after_reset", seen, 0);

    // Directed frames
    run_frame(16'h0000, 16'd150, 1'b0);
    run_frame(16'hFFFF, 16'd150, 1'b0);
    run_frame(16'h0000, 16'd300, 1'b0);
    run_frame(16'hFFFF, 16'd300, 1'b0);
    run_frame(16'h0000, 16'd600, 1'b0);
    run_frame(16'hFFFF, 16'd600, 1'b0);
    run_frame(16'h5555, 16'd150, 1'b1);

    // Random frames, including unknown modes that fall back to DSHOT150
    for (int k = 0; k < 4; k++) begin
      logic [15:0] rm;
      case ($urandom_range(0, 3))
        0:       rm = 16'd600;
        1:       rm = 16'd300;
        2:       rm = 16'(1000 + $urandom_range(0, 500));
        default: rm = 16'd600;
      endcase
      run_frame(16'($urandom), rm, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-frame aborts immediately
    val = 16'hFFFF; mode = 16'd600; wr = 1'b1;
    step();
    wr = 1'b0;
    repeat (40) step();
    chk("abort_mid_high", int'(line()), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_pwm", int'(line()), 0);
    chk("abort_ready", int'(rdy), 1);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (line() || !rdy) seen++;
    end
    chk("idle_after_abort", seen, 0);

    // A fresh frame after the abort still runs normally
    run_frame(16'hA5C3, 16'd600, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
